// File: rtl/num_deser.sv
// ============================================================================
// Module      : num_deser
// Description : MSB-first serial-to-2-bit symbol deserializer feeding the
//               sequence detector's num input. Define PARITY_EN to enable
//               3-bit frames with an odd-parity check and error counting.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module num_deser #(
    parameter int SYM_CNT_W = 8,
    parameter int ERR_CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    input  logic                 sync,
    output logic [1:0]           num,
    output logic                 num_valid,
    output logic                 parity_err,
    output logic [SYM_CNT_W-1:0] sym_cnt,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [1:0] c_ST_MSB = 2'd0;
    localparam logic [1:0] c_ST_LSB = 2'd1;
`ifdef PARITY_EN
    localparam logic [1:0] c_ST_PAR = 2'd2;
`endif

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic       r_b1;
    logic       w_accept;
`ifdef PARITY_EN
    logic                 r_b0;
    logic                 r_perr;
    logic [ERR_CNT_W-1:0] r_err;
    logic                 w_drop;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_MSB;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: a valid bit under sync always restarts as an MSB
    always_comb begin
        w_state_next = r_state;
        if (bit_valid) begin
            if (sync) begin
                w_state_next = c_ST_LSB;
            end else begin
                case (r_state)
                    c_ST_MSB: w_state_next = c_ST_LSB;
`ifdef PARITY_EN
                    c_ST_LSB: w_state_next = c_ST_PAR;
                    c_ST_PAR: w_state_next = c_ST_MSB;
`else
                    c_ST_LSB: w_state_next = c_ST_MSB;
`endif
                    default:  w_state_next = c_ST_MSB;
                endcase
            end
        end else if (sync) begin
            w_state_next = c_ST_MSB;
        end
    end

    // Output decode: frame completion events
    always_comb begin
        w_accept = 1'b0;
`ifdef PARITY_EN
        w_drop   = 1'b0;
        if (bit_valid && !sync && (r_state == c_ST_PAR)) begin
            if (r_b1 ^ r_b0 ^ bit_in) begin
                w_accept = 1'b1;
            end else begin
                w_drop = 1'b1;
            end
        end
`else
        if (bit_valid && !sync && (r_state == c_ST_LSB)) begin
            w_accept = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_b1      <= 1'b0;
            num       <= 2'b00;
            num_valid <= 1'b0;
            sym_cnt   <= '0;
        end else begin
            num_valid <= w_accept;
            if (bit_valid && (sync || (r_state == c_ST_MSB))) begin
                r_b1 <= bit_in;
            end
            if (w_accept) begin
`ifdef PARITY_EN
                num <= {r_b1, r_b0};
`else
                num <= {r_b1, bit_in};
`endif
                sym_cnt <= sym_cnt + SYM_CNT_W'(1);
            end
        end
    end

`ifdef PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_b0   <= 1'b0;
            r_perr <= 1'b0;
            r_err  <= '0;
        end else begin
            r_perr <= w_drop;
            if (bit_valid && !sync && (r_state == c_ST_LSB)) begin
                r_b0 <= bit_in;
            end
            if (w_drop && (r_err != {ERR_CNT_W{1'b1}})) begin
                r_err <= r_err + ERR_CNT_W'(1);
            end
        end
    end

    assign parity_err = r_perr;
    assign err_cnt    = r_err;
`else
    assign parity_err = 1'b0;
    assign err_cnt    = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_num_deser.sv
// ============================================================================
// Module      : tb_num_deser
// Description : Self-checking bench for num_deser (either PARITY_EN setting).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_num_deser;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       sync = 1'b0;
    logic [1:0] num;
    logic       num_valid;
    logic       parity_err;
    logic [7:0] sym_cnt;
    logic [3:0] err_cnt;

    int n_pass = 0;
    int n_total = 0;

    num_deser #(.SYM_CNT_W(8), .ERR_CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .sync      (sync),
        .num       (num),
        .num_valid (num_valid),
        .parity_err(parity_err),
        .sym_cnt   (sym_cnt),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       bi;
        logic       bv;
        logic       sy;
        logic [1:0] num;
        logic       nv;
        logic [7:0] cnt;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive at negedge, sample 1 time unit after the next rising edge
    task automatic step(input logic bi, input logic bv, input logic sy);
        @(negedge clk);
        bit_in    = bi;
        bit_valid = bv;
        sync      = sy;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        sync      = 1'b0;
    endtask

    task automatic send_frame(input logic b1, input logic b0, input logic good);
        step(b1, 1'b1, 1'b0);
        step(b0, 1'b1, 1'b0);
`ifdef PARITY_EN
        step(good ? ~(b1 ^ b0) : (b1 ^ b0), 1'b1, 1'b0);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        vec_t tbl[22];
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 8'd0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 8'd1};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 8'd1};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 8'd2};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 8'd2};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 2'b11, 1'b1, 8'd3};
        // mid-frame sync with a valid bit restarts the frame
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 8'd3};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 8'd3};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 8'd4};
        // 3-cycle gap between bits of a frame
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 8'd4};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 8'd4};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 8'd4};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 8'd4};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 8'd5};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 8'd5};
        // sync without a valid bit discards the partial frame
        tbl[15] = '{1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 8'd5};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 8'd5};
        tbl[17] = '{1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 8'd5};
        tbl[18] = '{1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 8'd6};
        // sync in MSB with no valid bit is a no-op
        tbl[19] = '{1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 8'd6};
        tbl[20] = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 8'd6};
        tbl[21] = '{1'b1, 1'b1, 1'b0, 2'b11, 1'b1, 8'd7};

        #3;
        chk("reset_num", {30'd0, num}, 32'd0);
        chk("reset_nv", {31'd0, num_valid}, 32'd0);
        chk("reset_cnt", {24'd0, sym_cnt}, 32'd0);
        chk("reset_err", {28'd0, err_cnt}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

`ifndef PARITY_EN
        for (int i = 0; i < 22; i++) begin
            step(tbl[i].bi, tbl[i].bv, tbl[i].sy);
            chk($sformatf("vec%0d_num", i), {30'd0, num}, {30'd0, tbl[i].num});
            chk($sformatf("vec%0d_nv", i), {31'd0, num_valid}, {31'd0, tbl[i].nv});
            chk($sformatf("vec%0d_cnt", i), {24'd0, sym_cnt}, {24'd0, tbl[i].cnt});
            chk($sformatf("vec%0d_perr", i), {31'd0, parity_err}, 32'd0);
        end
        chk("nopar_err_cnt", {28'd0, err_cnt}, 32'd0);
`else
        send_frame(1'b0, 1'b1, 1'b1);
        chk("par_good_num", {30'd0, num}, 32'd1);
        chk("par_good_nv", {31'd0, num_valid}, 32'd1);
        chk("par_good_perr", {31'd0, parity_err}, 32'd0);
        send_frame(1'b0, 1'b1, 1'b0);
        chk("par_bad_num", {30'd0, num}, 32'd1);
        chk("par_bad_nv", {31'd0, num_valid}, 32'd0);
        chk("par_bad_perr", {31'd0, parity_err}, 32'd1);
        chk("par_bad_err", {28'd0, err_cnt}, 32'd1);
        chk("par_bad_cnt", {24'd0, sym_cnt}, 32'd1);
        step(1'b0, 1'b0, 1'b0);
        chk("par_perr_width", {31'd0, parity_err}, 32'd0);
        for (int i = 0; i < 13; i++) send_frame(1'b1, 1'b1, 1'b0);
        chk("par_err_14", {28'd0, err_cnt}, 32'd14);
        for (int i = 0; i < 7; i++) send_frame(1'b1, 1'b0, 1'b0);
        chk("par_err_sat", {28'd0, err_cnt}, 32'd15);
        chk("par_err_num", {30'd0, num}, 32'd1);
`endif

        // sym_cnt wrap
        do_reset();
        for (int i = 0; i < 255; i++) send_frame(1'b1, 1'b0, 1'b1);
        chk("wrap_255", {24'd0, sym_cnt}, 32'd255);
        send_frame(1'b1, 1'b0, 1'b1);
        chk("wrap_0", {24'd0, sym_cnt}, 32'd0);
        chk("wrap_num", {30'd0, num}, 32'd2);

        // asynchronous reset mid-frame
        send_frame(1'b1, 1'b1, 1'b1);
        chk("pre_rst_num", {30'd0, num}, 32'd3);
        step(1'b1, 1'b1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_num", {30'd0, num}, 32'd0);
        chk("arst_cnt", {24'd0, sym_cnt}, 32'd0);
        chk("arst_nv", {31'd0, num_valid}, 32'd0);
        chk("arst_perr", {31'd0, parity_err}, 32'd0);
        reset = 1'b0;
        step(1'b1, 1'b1, 1'b0);
        chk("arst_b1_nv", {31'd0, num_valid}, 32'd0);
        chk("arst_b1_num", {30'd0, num}, 32'd0);
        step(1'b0, 1'b1, 1'b0);
`ifdef PARITY_EN
        step(1'b0, 1'b1, 1'b0);
`endif
        chk("arst_frame_num", {30'd0, num}, 32'd2);
        chk("arst_frame_nv", {31'd0, num_valid}, 32'd1);
        chk("arst_frame_cnt", {24'd0, sym_cnt}, 32'd1);
        step(1'b0, 1'b0, 1'b0);
        chk("nv_width", {31'd0, num_valid}, 32'd0);
        chk("num_held", {30'd0, num}, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // num_valid and parity_err must never coincide
    always @(posedge clk) begin
        #1;
        if (num_valid && parity_err) begin
            n_total++;
            $display("FAIL excl_pulses: num_valid=%0b parity_err=%0b expected not both", num_valid, parity_err);
        end
    end

endmodule

`default_nettype wire
